// File: rtl/rx_frame_timer.sv
// rx_frame_timer: edge/bit timing for a UART receiver frame.
// Counts oversampling clocks within each bit and bits within the frame.
// Takes a three-point majority vote around the bit centre.
// Flags frame completion, frame abort and illegal configuration.
module rx_frame_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_bits,
  input  logic                  par_en,
  input  logic                  stop2,
  input  logic                  rx_in,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_valid,
  output logic                  sampled_bit,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  cfg_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e                state_q,       state_d;
  logic [PRESCALE_W-1:0] edgeCnt_q,     edgeCnt_d;
  logic [BIT_CNT_W-1:0]  bitCnt_q,      bitCnt_d;
  logic [PRESCALE_W-1:0] presc_q,       presc_d;
  logic [3:0]            dataBits_q,    dataBits_d;
  logic                  parEn_q,       parEn_d;
  logic                  stop2_q,       stop2_d;
  logic [1:0]            samples_q,     samples_d;
  logic                  sampleValid_q, sampleValid_d;
  logic                  sampledBit_q,  sampledBit_d;
  logic                  frameDone_q,   frameDone_d;
  logic                  frameAbort_q,  frameAbort_d;
  logic                  cfgErr_q,      cfgErr_d;
  logic                  busy_q,        busy_d;

  logic                  cfgLegal;
  logic [PRESCALE_W-1:0] lastEdge;
  logic [PRESCALE_W-1:0] midEdge;
  logic [PRESCALE_W-1:0] preMidEdge;
  logic [PRESCALE_W-1:0] postMidEdge;
  logic [BIT_CNT_W-1:0]  lastBit;
  logic                  voteBit;

  // Judge the live configuration inputs; only consulted when a frame is requested
  always_comb begin
    cfgLegal = (prescale >= PRESCALE_W'(4)) &&
               (data_bits >= 4'd5) &&
               (data_bits <= 4'd8);
  end

  // Frame geometry derived from the shadow copy so mid-frame input changes cannot disturb it
  always_comb begin
    lastEdge    = presc_q - PRESCALE_W'(1);
    midEdge     = presc_q >> 1;
    preMidEdge  = midEdge - PRESCALE_W'(1);
    postMidEdge = midEdge + PRESCALE_W'(1);
    lastBit     = BIT_CNT_W'(dataBits_q) + BIT_CNT_W'(parEn_q) +
                  BIT_CNT_W'(stop2_q) + BIT_CNT_W'(1);
  end

  // Two-of-three vote: the first two captures are stored, the third is the live line
  always_comb begin
    voteBit = (samples_q[0] & samples_q[1]) |
              (samples_q[0] & rx_in) |
              (samples_q[1] & rx_in);
  end

  // Next state and next register values; pulses and counters fall back to zero by default
  always_comb begin
    state_d       = state_q;
    edgeCnt_d     = '0;
    bitCnt_d      = '0;
    presc_d       = presc_q;
    dataBits_d    = dataBits_q;
    parEn_d       = parEn_q;
    stop2_d       = stop2_q;
    samples_d     = samples_q;
    sampleValid_d = 1'b0;
    sampledBit_d  = sampledBit_q;
    frameDone_d   = 1'b0;
    frameAbort_d  = 1'b0;
    cfgErr_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (cfgLegal) begin
            presc_d    = prescale;
            dataBits_d = data_bits;
            parEn_d    = par_en;
            stop2_d    = stop2;
            edgeCnt_d  = PRESCALE_W'(1);
            state_d    = RUN;
          end else begin
            cfgErr_d = 1'b1;
            state_d  = ERR;
          end
        end
      end

      RUN: begin
        if (!enable) begin
          frameAbort_d = 1'b1;
          state_d      = IDLE;
        end else begin
          if (edgeCnt_q == preMidEdge) begin
            samples_d[0] = rx_in;
          end
          if (edgeCnt_q == midEdge) begin
            samples_d[1] = rx_in;
          end
          if (edgeCnt_q == postMidEdge) begin
            sampledBit_d  = voteBit;
            sampleValid_d = 1'b1;
          end

          if (edgeCnt_q == lastEdge) begin
            edgeCnt_d = '0;
            if (bitCnt_q == lastBit) begin
              bitCnt_d    = '0;
              frameDone_d = 1'b1;
              state_d     = IDLE;
            end else begin
              bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
            end
          end else begin
            edgeCnt_d = edgeCnt_q + PRESCALE_W'(1);
            bitCnt_d  = bitCnt_q;
          end
        end
      end

      ERR: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State register; reset drops straight back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, shadow configuration, vote captures and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edgeCnt_q     <= '0;
      bitCnt_q      <= '0;
      presc_q       <= '0;
      dataBits_q    <= '0;
      parEn_q       <= 1'b0;
      stop2_q       <= 1'b0;
      samples_q     <= '0;
      sampleValid_q <= 1'b0;
      sampledBit_q  <= 1'b0;
      frameDone_q   <= 1'b0;
      frameAbort_q  <= 1'b0;
      cfgErr_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      edgeCnt_q     <= edgeCnt_d;
      bitCnt_q      <= bitCnt_d;
      presc_q       <= presc_d;
      dataBits_q    <= dataBits_d;
      parEn_q       <= parEn_d;
      stop2_q       <= stop2_d;
      samples_q     <= samples_d;
      sampleValid_q <= sampleValid_d;
      sampledBit_q  <= sampledBit_d;
      frameDone_q   <= frameDone_d;
      frameAbort_q  <= frameAbort_d;
      cfgErr_q      <= cfgErr_d;
      busy_q        <= busy_d;
    end
  end

  assign edge_cnt     = edgeCnt_q;
  assign bit_cnt      = bitCnt_q;
  assign sample_valid = sampleValid_q;
  assign sampled_bit  = sampledBit_q;
  assign frame_done   = frameDone_q;
  assign frame_abort  = frameAbort_q;
  assign cfg_err      = cfgErr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rx_frame_timer.sv
// tb_rx_frame_timer: scoreboard bench for rx_frame_timer.
// Expected pulses are queued when a frame is driven and matched as the DUT emits them.
module tb_rx_frame_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  localparam int EV_SAMPLE = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_ABORT  = 2;
  localparam int EV_CFGERR = 3;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [3:0]    data_bits;
  logic          par_en;
  logic          stop2;
  logic          rx_in;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_valid;
  logic          sampled_bit;
  logic          frame_done;
  logic          frame_abort;
  logic          cfg_err;
  logic          busy;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } evt_t;

  evt_t sbQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   cyc = 0;

  rx_frame_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .prescale     (prescale),
    .data_bits    (data_bits),
    .par_en       (par_en),
    .stop2        (stop2),
    .rx_in        (rx_in),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .cfg_err      (cfg_err),
    .busy         (busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to time-stamp expected and observed pulses
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the flow ever stalls
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic pushEvt(input int kind, input int c, input int v);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    sbQ.push_back(e);
  endtask

  task automatic handleEvent(input int kind, input int val);
    evt_t e;
    if (sbQ.size() == 0) begin
      checkOutput("unexpected_pulse_kind", kind, 32'hFFFF);
    end else begin
      e = sbQ.pop_front();
      checkOutput("evt_kind", kind, e.kind);
      checkOutput("evt_cycle", cyc, e.cyc);
      if (kind == EV_SAMPLE) checkOutput("sampled_bit", val, e.val);
    end
  endtask

  // Pulse monitor: match each pulse against the scoreboard, then flag any event left overdue
  always @(negedge clk) begin
    if (rst) begin
      if (sample_valid) handleEvent(EV_SAMPLE, 32'(sampled_bit));
      if (frame_done)   handleEvent(EV_DONE, 0);
      if (frame_abort)  handleEvent(EV_ABORT, 0);
      if (cfg_err)      handleEvent(EV_CFGERR, 0);
      while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
        checkOutput("missed_event_kind", 32'hFFFF, sbQ[0].kind);
        void'(sbQ.pop_front());
      end
    end
  end

  task automatic checkIdle();
    checkOutput("idle_edge_cnt", 32'(edge_cnt), 0);
    checkOutput("idle_bit_cnt", 32'(bit_cnt), 0);
    checkOutput("idle_busy", 32'(busy), 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkIdle();
    end
  endtask

  task automatic buildFrame(input logic [7:0] data, input int db, input bit par, input bit st2,
                            output logic [11:0] bits, output int len);
    logic parity;
    parity  = 1'b0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < db; j++) begin
      bits[1+j] = data[j];
      parity    = parity ^ data[j];
    end
    if (par) bits[1+db] = parity;
    len = 2 + db + (par ? 1 : 0) + (st2 ? 1 : 0);
  endtask

  // Drive one frame edge by edge; stopKind 1 drops enable at stopAt, 2 asserts reset at stopAt
  task automatic applyStimulus(input int p, input int db, input bit par, input bit st2,
                               input logic [7:0] data, input int glitchAt, input int chgAt,
                               input int chgVal, input int stopAt, input int stopKind);
    logic [11:0] bits;
    int len;
    int base;
    int mid;
    int limit;
    int smp;
    int votes;
    buildFrame(data, db, par, st2, bits, len);
    base  = cyc;
    mid   = p / 2;
    limit = (stopKind == 0) ? (1 << 30) : ((stopKind == 1) ? stopAt : stopAt - 1);
    for (int i = 0; i < len; i++) begin
      smp = i * p + mid + 2;
      if (smp <= limit) begin
        votes = 0;
        for (int j = mid - 1; j <= mid + 1; j++)
          votes += ((bits[i] ^ (i * p + j == glitchAt)) != 1'b0) ? 1 : 0;
        pushEvt(EV_SAMPLE, base + smp, (votes >= 2) ? 1 : 0);
      end
    end
    if (stopKind == 0) pushEvt(EV_DONE, base + len * p, 0);
    if (stopKind == 1) pushEvt(EV_ABORT, base + stopAt + 1, 0);

    prescale  = PW'(p);
    data_bits = 4'(db);
    par_en    = par;
    stop2     = st2;
    enable    = 1'b1;
    for (int k = 0; k < len * p; k++) begin
      checkOutput("edge_cnt", 32'(edge_cnt), k % p);
      checkOutput("bit_cnt", 32'(bit_cnt), k / p);
      checkOutput("busy", 32'(busy), (k != 0) ? 1 : 0);
      if (stopKind == 1 && k == stopAt) begin
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_edge_cnt", 32'(edge_cnt), 0);
        checkOutput("abort_bit_cnt", 32'(bit_cnt), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        return;
      end
      if (stopKind == 2 && k == stopAt) begin
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_edge_cnt", 32'(edge_cnt), 0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_sampled_bit", 32'(sampled_bit), 0);
        checkOutput("rst_sample_valid", 32'(sample_valid), 0);
        enable = 1'b0;
        return;
      end
      if (k == chgAt) begin
        prescale  = PW'(chgVal);
        data_bits = 4'd5;
        par_en    = ~par;
        stop2     = ~st2;
      end
      rx_in = bits[k/p] ^ (k == glitchAt);
      @(posedge clk);
      #1;
    end
  endtask

  // Request a frame with an illegal configuration and confirm a lone cfg_err and no run
  task automatic cfgErrCase(input int p, input int db);
    pushEvt(EV_CFGERR, cyc + 1, 0);
    prescale  = PW'(p);
    data_bits = 4'(db);
    enable    = 1'b1;
    idleCycles(4);
    enable = 1'b0;
    idleCycles(2);
  endtask

  initial begin
    rst       = 1'b0;
    enable    = 1'b0;
    prescale  = PW'(8);
    data_bits = 4'd8;
    par_en    = 1'b0;
    stop2     = 1'b0;
    rx_in     = 1'b1;
    #1;
    checkIdle();
    checkOutput("reset_sample_valid", 32'(sample_valid), 0);
    checkOutput("reset_sampled_bit", 32'(sampled_bit), 0);
    checkOutput("reset_frame_done", 32'(frame_done), 0);
    checkOutput("reset_frame_abort", 32'(frame_abort), 0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 8N1 frame, prescale 8, data 0xA5");
    applyStimulus(8, 8, 1'b0, 1'b0, 8'hA5, -1, -1, 0, -1, 0);
    enable = 1'b0;
    idleCycles(3);

    $display("[TB] 7E2 frame, prescale 16, start-bit glitch");
    applyStimulus(16, 7, 1'b1, 1'b1, 8'h5A, 8, -1, 0, -1, 0);
    enable = 1'b0;
    idleCycles(3);

    $display("[TB] back-to-back frames, prescale 8 then 12");
    applyStimulus(8, 8, 1'b0, 1'b0, 8'h3C, -1, 40, 12, -1, 0);
    applyStimulus(12, 8, 1'b0, 1'b0, 8'hC3, -1, -1, 0, -1, 0);
    enable = 1'b0;
    idleCycles(3);

    $display("[TB] enable dropped mid-frame");
    applyStimulus(8, 8, 1'b0, 1'b0, 8'hA5, -1, -1, 0, 35, 1);
    idleCycles(2);
    applyStimulus(8, 8, 1'b0, 1'b0, 8'h96, -1, -1, 0, 13, 1);
    idleCycles(2);
    applyStimulus(8, 5, 1'b0, 1'b0, 8'h15, -1, -1, 0, 55, 1);
    idleCycles(2);

    $display("[TB] illegal configurations and recovery");
    cfgErrCase(3, 8);
    cfgErrCase(8, 9);
    cfgErrCase(8, 4);
    applyStimulus(4, 5, 1'b0, 1'b0, 8'h0B, -1, -1, 0, -1, 0);
    enable = 1'b0;
    idleCycles(2);

    $display("[TB] reset mid-frame");
    applyStimulus(8, 8, 1'b0, 1'b0, 8'hFF, -1, -1, 0, 50, 2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdle();
    applyStimulus(8, 8, 1'b0, 1'b0, 8'hA5, -1, -1, 0, -1, 0);
    enable = 1'b0;
    idleCycles(4);

    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
